// File: rtl/arcade_input_cond.sv
// arcade_input_cond: per-player debounce, 4-way/8-way direction rules and coin pulse shaping.
// Latency: 2^DEBOUNCE_W + 3 clk from first sample to any button/direction; coin 1 clk after debounced rise.
// Backpressure: none; inputs free-running, outputs are levels. Autofire option: ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_cond #(
    parameter int DEBOUNCE_W    = 10,
    parameter int COIN_PULSE    = 2000000,
    parameter int COIN_LOCKOUT  = 2000000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    parameter int AUTOFIRE_HALF = 1000000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] joy_in,
    input  logic       mode_4way,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic       autofire,
`endif
    output logic [3:0] dir_out,
    output logic       fire,
    output logic       bomb,
    output logic       start1,
    output logic       start2,
    output logic       pause,
    output logic       coin
);

    typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT, WAIT_REL} coin_state_t;

    localparam int TMAX = (COIN_PULSE > COIN_LOCKOUT) ? COIN_PULSE : COIN_LOCKOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(COIN_LOCKOUT - 1);

    logic [9:0]            s1;
    logic [9:0]            s2;
    logic [9:0]            deb;
    logic [DEBOUNCE_W-1:0] cnt [10];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < 10; i++) cnt[i] <= '0;
        end else begin
            s1 <= joy_in;
            s2 <= s1;
            for (int i = 0; i < 10; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (&cnt[i]) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0] deb_dir;
    logic [3:0] deb_dir_d;
    logic [3:0] dir_rise;
    logic [3:0] dir_next;
    logic       mode_q;

    assign deb_dir  = deb[3:0];
    assign dir_rise = deb_dir & ~deb_dir_d;

    function automatic logic [3:0] prio4(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    // In 4-way mode dir_out is the one-hot mask; a fresh rise wins before any release is considered.
    always_comb begin
        dir_next = dir_out;
        if (!mode_4way) begin
            dir_next = deb_dir;
            if (deb_dir[3] && deb_dir[2]) dir_next[3:2] = 2'b00;
            if (deb_dir[1] && deb_dir[0]) dir_next[1:0] = 2'b00;
        end else if (!mode_q) begin
            dir_next = prio4(deb_dir);
        end else if (|dir_rise) begin
            dir_next = prio4(dir_rise);
        end else if (|(dir_out & ~deb_dir)) begin
            dir_next = prio4(deb_dir);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir_out   <= '0;
            deb_dir_d <= '0;
            mode_q    <= 1'b0;
            bomb      <= 1'b0;
            start1    <= 1'b0;
            start2    <= 1'b0;
            pause     <= 1'b0;
        end else begin
            dir_out   <= dir_next;
            deb_dir_d <= deb_dir;
            mode_q    <= mode_4way;
            bomb      <= deb[5];
            start1    <= deb[6];
            start2    <= deb[7];
            pause     <= deb[9];
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
    localparam logic [AW-1:0] AF_LOAD = AW'(AUTOFIRE_HALF - 1);

    logic [AW-1:0] af_cnt;
    logic          af_active;

    // Leaving autofire forces one low cycle so the next burst always starts on a fresh phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fire      <= 1'b0;
            af_cnt    <= '0;
            af_active <= 1'b0;
        end else if (autofire && deb[4]) begin
            if (!af_active) begin
                fire      <= 1'b1;
                af_cnt    <= AF_LOAD;
                af_active <= 1'b1;
            end else if (af_cnt == '0) begin
                fire   <= ~fire;
                af_cnt <= AF_LOAD;
            end else begin
                af_cnt <= af_cnt - 1'b1;
            end
        end else if (af_active) begin
            fire      <= 1'b0;
            af_cnt    <= '0;
            af_active <= 1'b0;
        end else begin
            fire <= deb[4];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) fire <= 1'b0;
        else          fire <= deb[4];
    end
`endif

    coin_state_t   state;
    coin_state_t   state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          deb_coin;
    logic          deb_coin_d;
    logic          coin_quiet;
    logic          coin_quiet_d;

    assign deb_coin = deb[8];
    // Release needs the whole coin path low for two cycles, so a coin held through reset
    // is seen entering the synchroniser before WAIT_REL can let go.
    assign coin_quiet = !(s1[8] || s2[8] || deb[8]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= WAIT_REL;
            timer        <= '0;
            deb_coin_d   <= 1'b0;
            coin_quiet_d <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            deb_coin_d   <= deb_coin;
            coin_quiet_d <= coin_quiet;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        coin       = 1'b0;
        case (state)
            IDLE: begin
                if (deb_coin && !deb_coin_d) begin
                    state_next = PULSE;
                    timer_next = PULSE_LOAD;
                end
            end
            PULSE: begin
                coin = 1'b1;
                if (timer == '0) begin
                    state_next = LOCKOUT;
                    timer_next = LOCK_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer == '0) state_next = deb_coin ? WAIT_REL : IDLE;
                else             timer_next = timer - 1'b1;
            end
            WAIT_REL: begin
                if (coin_quiet && coin_quiet_d) state_next = IDLE;
            end
            default: state_next = WAIT_REL;
        endcase
    end

endmodule
